// File: rtl/madgwick_stream_ctrl.sv
// madgwick_stream_ctrl: sequences raw IMU samples into the madgwick filter
// core and holds the latest quaternion plus status for the register block.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. As initiator (valid_in/ready_in) the controller raises
// valid_in and holds the sample outputs stable until ready_in is seen. As
// responder (valid_out/ready_out) it raises ready_out while waiting and takes
// the quaternion on the first cycle valid_out is high. Only one filter
// transaction is in flight at a time. While one is in flight, a single
// pending slot holds the newest sample that has not been sent yet.
module madgwick_stream_ctrl #(
  parameter int                          ACC_WIDTH  = 11,
  parameter int                          GYRO_WIDTH = 10,
  parameter int                          Q_WIDTH    = 16,
  parameter logic signed [Q_WIDTH-1:0]   Q_ONE      = 16'sh4000,
  parameter int                          CNT_WIDTH  = 8,
  parameter int                          TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sample_valid,
  input  logic signed [ACC_WIDTH-1:0]   a_x_in,
  input  logic signed [ACC_WIDTH-1:0]   a_y_in,
  input  logic signed [ACC_WIDTH-1:0]   a_z_in,
  input  logic signed [GYRO_WIDTH-1:0]  w_x_in,
  input  logic signed [GYRO_WIDTH-1:0]  w_y_in,
  input  logic signed [GYRO_WIDTH-1:0]  w_z_in,
  output logic                          valid_in,
  input  logic                          ready_in,
  output logic signed [ACC_WIDTH-1:0]   a_x,
  output logic signed [ACC_WIDTH-1:0]   a_y,
  output logic signed [ACC_WIDTH-1:0]   a_z,
  output logic signed [GYRO_WIDTH-1:0]  w_x,
  output logic signed [GYRO_WIDTH-1:0]  w_y,
  output logic signed [GYRO_WIDTH-1:0]  w_z,
  input  logic                          valid_out,
  output logic                          ready_out,
  input  logic signed [Q_WIDTH-1:0]     q_w,
  input  logic signed [Q_WIDTH-1:0]     q_x,
  input  logic signed [Q_WIDTH-1:0]     q_y,
  input  logic signed [Q_WIDTH-1:0]     q_z,
  output logic signed [Q_WIDTH-1:0]     q_w_o,
  output logic signed [Q_WIDTH-1:0]     q_x_o,
  output logic signed [Q_WIDTH-1:0]     q_y_o,
  output logic signed [Q_WIDTH-1:0]     q_z_o,
  output logic [CNT_WIDTH-1:0]          q_seq,
  output logic [CNT_WIDTH-1:0]          drop_cnt,
  output logic                          q_new,
  input  logic                          clr_new,
  output logic                          timeout_err,
  output logic                          busy,
  output logic [1:0]                    state_dbg
);

  localparam int SW = 3 * ACC_WIDTH + 3 * GYRO_WIDTH;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [SW-1:0]   in_vec;
  logic [SW-1:0]   sample_r;
  logic [SW-1:0]   pend_r;
  logic            pend_valid;
  logic [TW-1:0]   tcnt;

  logic load_in;
  logic load_pend;
  logic pend_set;
  logic pend_clr;
  logic drop_inc;
  logic tcnt_clr;
  logic tcnt_inc;
  logic capture;
  logic abort;

  assign in_vec = {a_x_in, a_y_in, a_z_in, w_x_in, w_y_in, w_z_in};
  assign {a_x, a_y, a_z, w_x, w_y, w_z} = sample_r;
  assign state_dbg = state;

  // Next-state and datapath control; the pending slot is only touched while busy.
  always_comb begin
    state_next = state;
    load_in    = 1'b0;
    load_pend  = 1'b0;
    pend_set   = 1'b0;
    pend_clr   = 1'b0;
    drop_inc   = 1'b0;
    tcnt_clr   = 1'b0;
    tcnt_inc   = 1'b0;
    capture    = (state == S_WAIT) && valid_out;
    abort      = (state == S_WAIT) && !valid_out && (tcnt == TCNT_LAST);
    case (state)
      S_IDLE: begin
        if (sample_valid) begin
          load_in    = 1'b1;
          state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (ready_in) begin
          state_next = S_WAIT;
          tcnt_clr   = 1'b1;
        end
        if (sample_valid) begin
          pend_set = 1'b1;
          drop_inc = pend_valid;
        end
      end
      S_WAIT: begin
        if (capture || abort) begin
          if (pend_valid) begin
            // Oldest unsent sample goes first; a same-cycle strobe refills the slot.
            load_pend  = 1'b1;
            state_next = S_SEND;
            if (sample_valid) pend_set = 1'b1;
            else              pend_clr = 1'b1;
          end else if (sample_valid) begin
            load_in    = 1'b1;
            state_next = S_SEND;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          tcnt_inc = 1'b1;
          if (sample_valid) begin
            pend_set = 1'b1;
            drop_inc = pend_valid;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Sample registers toward the filter, pending slot and WAIT_Q timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_r   <= '0;
      pend_r     <= '0;
      pend_valid <= 1'b0;
      tcnt       <= '0;
    end else begin
      if (load_in)        sample_r <= in_vec;
      else if (load_pend) sample_r <= pend_r;
      if (pend_set) begin
        pend_r     <= in_vec;
        pend_valid <= 1'b1;
      end else if (pend_clr) begin
        pend_valid <= 1'b0;
      end
      if (tcnt_clr)      tcnt <= '0;
      else if (tcnt_inc) tcnt <= tcnt + TW'(1);
    end
  end

  // State register, registered handshake/busy outputs and quaternion status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      valid_in    <= 1'b0;
      ready_out   <= 1'b0;
      busy        <= 1'b0;
      q_w_o       <= Q_ONE;
      q_x_o       <= '0;
      q_y_o       <= '0;
      q_z_o       <= '0;
      q_seq       <= '0;
      drop_cnt    <= '0;
      q_new       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state     <= state_next;
      valid_in  <= (state_next == S_SEND);
      ready_out <= (state_next == S_WAIT);
      busy      <= (state_next != S_IDLE);
      if (capture) begin
        q_w_o <= q_w;
        q_x_o <= q_x;
        q_y_o <= q_y;
        q_z_o <= q_z;
        q_seq <= q_seq + CNT_WIDTH'(1);
      end
      if (drop_inc && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
      // A capture wins over a simultaneous clear so a fresh result is never hidden.
      if (capture)      q_new <= 1'b1;
      else if (clr_new) q_new <= 1'b0;
      if (abort) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_madgwick_stream_ctrl.sv
// Testbench for madgwick_stream_ctrl: directed scenarios followed by random
// traffic, checked against a transaction-level model through expected queues.
module tb_madgwick_stream_ctrl;

  localparam int AW = 11;
  localparam int GW = 10;
  localparam int QW = 16;
  localparam int CW = 8;
  localparam int TO = 16;
  localparam int SW = 3 * AW + 3 * GW;

  logic                  clk;
  logic                  rst_n;
  logic                  sample_valid;
  logic signed [AW-1:0]  a_x_in, a_y_in, a_z_in;
  logic signed [GW-1:0]  w_x_in, w_y_in, w_z_in;
  logic                  valid_in;
  logic                  ready_in;
  logic signed [AW-1:0]  a_x, a_y, a_z;
  logic signed [GW-1:0]  w_x, w_y, w_z;
  logic                  valid_out;
  logic                  ready_out;
  logic signed [QW-1:0]  q_w, q_x, q_y, q_z;
  logic signed [QW-1:0]  q_w_o, q_x_o, q_y_o, q_z_o;
  logic [CW-1:0]         q_seq;
  logic [CW-1:0]         drop_cnt;
  logic                  q_new;
  logic                  clr_new;
  logic                  timeout_err;
  logic                  busy;
  logic [1:0]            state_dbg;

  madgwick_stream_ctrl #(
    .ACC_WIDTH(AW), .GYRO_WIDTH(GW), .Q_WIDTH(QW), .Q_ONE(16'sh4000),
    .CNT_WIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .a_x_in(a_x_in), .a_y_in(a_y_in), .a_z_in(a_z_in),
    .w_x_in(w_x_in), .w_y_in(w_y_in), .w_z_in(w_z_in),
    .valid_in(valid_in), .ready_in(ready_in),
    .a_x(a_x), .a_y(a_y), .a_z(a_z), .w_x(w_x), .w_y(w_y), .w_z(w_z),
    .valid_out(valid_out), .ready_out(ready_out),
    .q_w(q_w), .q_x(q_x), .q_y(q_y), .q_z(q_z),
    .q_w_o(q_w_o), .q_x_o(q_x_o), .q_y_o(q_y_o), .q_z_o(q_z_o),
    .q_seq(q_seq), .drop_cnt(drop_cnt), .q_new(q_new), .clr_new(clr_new),
    .timeout_err(timeout_err), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: transaction phase (0 idle, 1 presenting, 2 awaiting q)
  int              m_phase;
  int              m_wcnt;
  logic [SW-1:0]   m_out;
  logic [63:0]     m_q;
  logic [CW-1:0]   m_seq;
  logic [CW-1:0]   m_drops;
  logic            m_qnew;
  logic            m_terr;
  logic [SW-1:0]   pend_q[$];

  // Scoreboard queues
  logic [SW-1:0]   exp_send_q[$];
  logic [71:0]     exp_cap_q[$];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_wcnt  = 0;
    m_out   = '0;
    m_q     = {16'h4000, 16'h0000, 16'h0000, 16'h0000};
    m_seq   = '0;
    m_drops = '0;
    m_qnew  = 1'b0;
    m_terr  = 1'b0;
    pend_q.delete();
    exp_send_q.delete();
    exp_cap_q.delete();
  endtask

  // Newest sample always wins the pending slot; replacing one counts a drop.
  function automatic logic [CW-1:0] pend_put(input logic [SW-1:0] s, input logic [CW-1:0] drops);
    if (pend_q.size() == 0) begin
      pend_q.push_back(s);
      return drops;
    end
    pend_q[0] = s;
    return (drops == '1) ? drops : drops + 8'd1;
  endfunction

  // Driver: apply one cycle of inputs, advance the model across the next edge.
  task automatic step(input logic sv, input logic [SW-1:0] smp, input logic rin,
                      input logic vout, input logic [63:0] qv, input logic clr);
    int            n_phase;
    int            n_wcnt;
    logic [SW-1:0] n_out;
    logic [63:0]   n_q;
    logic [CW-1:0] n_seq;
    logic [CW-1:0] n_drops;
    logic          n_qnew;
    logic          n_terr;
    logic          cap;
    logic          ab;
    sample_valid = sv;
    {a_x_in, a_y_in, a_z_in, w_x_in, w_y_in, w_z_in} = smp;
    ready_in  = rin;
    valid_out = vout;
    {q_w, q_x, q_y, q_z} = qv;
    clr_new   = clr;
    n_phase = m_phase; n_wcnt = m_wcnt; n_out = m_out; n_q = m_q;
    n_seq = m_seq; n_drops = m_drops; n_qnew = m_qnew; n_terr = m_terr;
    cap = (m_phase == 2) && vout;
    ab  = (m_phase == 2) && !vout && (m_wcnt == TO - 1);
    if (cap) begin
      n_q   = qv;
      n_seq = m_seq + 8'd1;
      exp_cap_q.push_back({qv, n_seq});
      n_qnew = 1'b1;
    end else if (clr) begin
      n_qnew = 1'b0;
    end
    if (ab) n_terr = 1'b1;
    if (m_phase == 0) begin
      if (sv) begin
        n_out = smp; exp_send_q.push_back(smp); n_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (rin) begin n_phase = 2; n_wcnt = 0; end
      if (sv) n_drops = pend_put(smp, m_drops);
    end else begin
      if (cap || ab) begin
        if (pend_q.size() != 0) begin
          n_out = pend_q.pop_front();
          exp_send_q.push_back(n_out);
          if (sv) pend_q.push_back(smp);
          n_phase = 1;
        end else if (sv) begin
          n_out = smp; exp_send_q.push_back(smp); n_phase = 1;
        end else begin
          n_phase = 0;
        end
      end else begin
        n_wcnt = m_wcnt + 1;
        if (sv) n_drops = pend_put(smp, m_drops);
      end
    end
    @(posedge clk);
    #1;
    m_phase = n_phase; m_wcnt = n_wcnt; m_out = n_out; m_q = n_q;
    m_seq = n_seq; m_drops = n_drops; m_qnew = n_qnew; m_terr = n_terr;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 64'h0, 1'b0);
  endtask

  function automatic logic [SW-1:0] rnd_smp();
    return SW'({$urandom(), $urandom()});
  endfunction

  // Monitor: per-cycle status against the model, handshakes against the queues
  initial begin
    logic [SW-1:0] es;
    logic [71:0]   ec;
    forever begin
      @(negedge clk);
      chk("valid_in", {71'd0, valid_in}, {71'd0, m_phase == 1});
      chk("ready_out", {71'd0, ready_out}, {71'd0, m_phase == 2});
      chk("busy", {71'd0, busy}, {71'd0, m_phase != 0});
      chk("sample_out", {9'd0, a_x, a_y, a_z, w_x, w_y, w_z}, {9'd0, m_out});
      chk("q_o", {8'd0, q_w_o, q_x_o, q_y_o, q_z_o}, {8'd0, m_q});
      chk("q_seq", {64'd0, q_seq}, {64'd0, m_seq});
      chk("drop_cnt", {64'd0, drop_cnt}, {64'd0, m_drops});
      chk("q_new", {71'd0, q_new}, {71'd0, m_qnew});
      chk("timeout_err", {71'd0, timeout_err}, {71'd0, m_terr});
      if (rst_n && valid_in && ready_in) begin
        if (exp_send_q.size() == 0) begin
          chk("send_unexpected", {71'd0, 1'b1}, 72'd0);
        end else begin
          es = exp_send_q.pop_front();
          chk("send_sample", {9'd0, a_x, a_y, a_z, w_x, w_y, w_z}, {9'd0, es});
        end
      end
      if (rst_n && valid_out && ready_out) begin
        if (exp_cap_q.size() == 0) begin
          chk("cap_unexpected", {71'd0, 1'b1}, 72'd0);
        end else begin
          ec = exp_cap_q.pop_front();
          @(posedge clk);
          #2;
          chk("cap_q_seq", {q_w_o, q_x_o, q_y_o, q_z_o, q_seq}, ec);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [SW-1:0] s1;
    logic [SW-1:0] s3;
    logic [63:0]   q1;
    s1 = {11'b11110111000, 11'b00101001010, 11'b00011000100,
          10'b1111001000, 10'b0000010111, 10'b1111010101};
    q1 = {16'h3F00, 16'h0100, 16'hFF00, 16'h0080};
    rst_n = 1'b0;
    sample_valid = 1'b0; ready_in = 1'b0; valid_out = 1'b0; clr_new = 1'b0;
    {a_x_in, a_y_in, a_z_in, w_x_in, w_y_in, w_z_in} = '0;
    {q_w, q_x, q_y, q_z} = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Basic transaction with the reference sample, filter stalls 5 cycles
    step(1'b1, s1, 1'b0, 1'b0, 64'h0, 1'b0);
    idle(5);
    step(1'b0, '0, 1'b1, 1'b0, 64'h0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, q1, 1'b0);
    chk("t1_q_w_o", {56'd0, q_w_o}, {56'd0, 16'h3F00});
    chk("t1_q_z_o", {56'd0, q_z_o}, {56'd0, 16'h0080});
    chk("t1_q_seq", {64'd0, q_seq}, 72'd1);
    chk("t1_q_new", {71'd0, q_new}, 72'd1);
    chk("t1_busy", {71'd0, busy}, 72'd0);

    // Three strobes while waiting: two drops, newest sent back-to-back
    step(1'b1, rnd_smp(), 1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 64'h0, 1'b0);
    step(1'b1, rnd_smp(), 1'b0, 1'b0, 64'h0, 1'b0);
    step(1'b1, rnd_smp(), 1'b0, 1'b0, 64'h0, 1'b0);
    s3 = rnd_smp();
    step(1'b1, s3, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("t3_drop_cnt", {64'd0, drop_cnt}, 72'd2);
    step(1'b0, '0, 1'b0, 1'b1, 64'h1111_2222_3333_4444, 1'b1);
    chk("t3_b2b_valid_in", {71'd0, valid_in}, 72'd1);
    chk("t3_b2b_sample", {9'd0, a_x, a_y, a_z, w_x, w_y, w_z}, {9'd0, s3});
    chk("t3_q_new_wins", {71'd0, q_new}, 72'd1);
    step(1'b0, '0, 1'b1, 1'b0, 64'h0, 1'b1);
    chk("t5_q_new_clr", {71'd0, q_new}, 72'd0);
    step(1'b0, '0, 1'b0, 1'b1, q1, 1'b0);

    // Timeout: filter never answers
    step(1'b1, rnd_smp(), 1'b1, 1'b0, 64'h0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < TO - 1; i++) step(1'b0, '0, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("t4_no_err_early", {71'd0, timeout_err}, 72'd0);
    step(1'b0, '0, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("t4_timeout_err", {71'd0, timeout_err}, 72'd1);
    chk("t4_idle", {71'd0, busy}, 72'd0);
    chk("t4_q_seq_kept", {64'd0, q_seq}, 72'd3);
    chk("t4_q_w_kept", {56'd0, q_w_o}, {56'd0, 16'h3F00});

    // Drop counter saturation while the filter stalls in the send phase
    step(1'b1, rnd_smp(), 1'b0, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, rnd_smp(), 1'b0, 1'b0, 64'h0, 1'b0);
    chk("sat_drop_cnt", {64'd0, drop_cnt}, 72'hFF);

    // Reset in the wait phase with a pending sample
    step(1'b0, '0, 1'b1, 1'b0, 64'h0, 1'b0);
    step(1'b1, rnd_smp(), 1'b0, 1'b0, 64'h0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_q_w_o", {56'd0, q_w_o}, {56'd0, 16'h4000});
    chk("rst_valid_in", {71'd0, valid_in}, 72'd0);
    chk("rst_drop_cnt", {64'd0, drop_cnt}, 72'd0);
    idle(3);
    rst_n = 1'b1;
    idle(5);
    chk("rst_no_stale_send", {71'd0, busy}, 72'd0);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 3) == 0), rnd_smp(), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 2) == 0), {$urandom(), $urandom()},
           ($urandom_range(0, 7) == 0));
    end

    // Drain outstanding work
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b1, {$urandom(), $urandom()}, 1'b0);
    idle(3);
    chk("drain_busy", {71'd0, busy}, 72'd0);
    chk("drain_send_q", 72'(exp_send_q.size()), 72'd0);
    chk("drain_cap_q", 72'(exp_cap_q.size()), 72'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/madgwick_stream_ctrl.md
# madgwick_stream_ctrl

Sequencer that sits between the raw IMU sample source and the `madgwick` filter core in the attitude_sensor peripheral. It latches sensor samples on a strobe, acts as the initiator on the filter's `valid_in`/`ready_in` input handshake, and acts as the responder on the filter's `valid_out`/`ready_out` output handshake. It holds the most recent quaternion, with sequence, drop and error status, for the SweRVolf register interface. One filter transaction is outstanding at a time, and a one-entry pending buffer absorbs samples that arrive while the filter is busy.

## Interface
- `ACC_WIDTH`, 11, accelerometer axis width (signed).
- `GYRO_WIDTH`, 10, gyro axis width (signed).
- `Q_WIDTH`, 16, quaternion component width (signed); must match the filter core.
- `Q_ONE`, 16'sh4000, reset value of `q_w_o` (identity quaternion).
- `CNT_WIDTH`, 8, width of `q_seq` and `drop_cnt`.
- `TIMEOUT`, 1024, cycles allowed in WAIT_Q before abort (≥2).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `sample_valid`  in  1  one-cycle strobe: sample inputs are valid.
- `a_x_in`/`a_y_in`/`a_z_in`  in  ACC_WIDTH each  raw accelerometer.
- `w_x_in`/`w_y_in`/`w_z_in`  in  GYRO_WIDTH each  raw gyro.
- `valid_in`  out  1  to filter: sample presented.
- `ready_in`  in  1  from filter: sample accepted.
- `a_x`/`a_y`/`a_z`, `w_x`/`w_y`/`w_z`  out  as above  sample to filter.
- `valid_out`  in  1  from filter: quaternion valid.
- `ready_out`  out  1  to filter: controller accepts quaternion.
- `q_w`/`q_x`/`q_y`/`q_z`  in  Q_WIDTH each  quaternion from filter.
- `q_w_o`/`q_x_o`/`q_y_o`/`q_z_o`  out  Q_WIDTH each  latched quaternion.
- `q_seq`  out  CNT_WIDTH  count of captured quaternions; wraps.
- `drop_cnt`  out  CNT_WIDTH  count of overwritten samples; saturates at all-ones.
- `q_new`  out  1  sticky flag: quaternion captured since the last clear.
- `clr_new`  in  1  clears `q_new`.
- `timeout_err`  out  1  sticky flag: WAIT_Q timed out. Cleared only by reset.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States:
  - IDLE: pending buffer is always empty here.
  - SEND: `valid_in`=1 and the filter sample outputs are held stable.
  - WAIT_Q: `ready_out`=1 and the timeout counter runs.
- IDLE + `sample_valid` → latch the inputs into the filter output registers, then go to SEND.
- SEND: when `valid_in && ready_in`, go to WAIT_Q and clear the timeout counter. There is no timeout in SEND.
- WAIT_Q, on `valid_out && ready_out` (capture):
  - Register `q_*` into `q_*_o`.
  - `q_seq` += 1.
  - Set `q_new`.
- WAIT_Q, at counter = TIMEOUT−1 with no handshake (abort):
  - Set `timeout_err`.
  - Leave `q_*_o` and `q_seq` unchanged.
- Exit from WAIT_Q, on capture or abort, in priority order:
  - Pending valid: load pending into the filter outputs and go to SEND. Pending becomes the current sample if `sample_valid`, otherwise empty.
  - Pending empty and `sample_valid`: load the sample directly and go to SEND.
  - Otherwise: go to IDLE.
- `sample_valid` in SEND, or in WAIT_Q without an exit:
  - Pending empty: fill the pending buffer.
  - Pending full: overwrite it with the newest sample and increment `drop_cnt` (saturating).
- Capture and `clr_new` in the same cycle: `q_new` ends at 1.

## Timing
- Reset values:
  - `valid_in`=0 and `ready_out`=0.
  - Filter sample outputs = 0.
  - `q_w_o`=Q_ONE; `q_x_o`, `q_y_o`, `q_z_o` = 0.
  - `q_seq`=0, `drop_cnt`=0.
  - `q_new`=0, `timeout_err`=0, `busy`=0.
  - State = IDLE, pending buffer empty.
- All outputs are registered.
- Strobe at cycle N in IDLE → `valid_in`=1 from N+1.
- Accept at N → `valid_in`=0 and `ready_out`=1 from N+1.
- Capture at M → `q_*_o`, `q_seq` and `q_new` updated from M+1, and `ready_out`=0 from M+1.
- On back-to-back exit to SEND, `valid_in`=1 from M+1.
- Abort at cycle TIMEOUT after entry to WAIT_Q → `ready_out`=0 and `timeout_err`=1 from the next cycle.
- Reset asserted mid-transaction: all state returns to reset values immediately and the pending sample is discarded.

## Test plan
- Reset release, then strobe with a_x=11'b11110111000, a_y=11'b00101001010, a_z=11'b00011000100, w_x=10'b1111001000, w_y=10'b0000010111, w_z=10'b1111010101 → `valid_in` asserts next cycle carrying those values. Filter returns q=(16'h3F00,16'h0100,16'hFF00,16'h0080) → `q_*_o` matches, `q_seq`=1, `q_new`=1, `busy`=0.
- Hold `ready_in`=0 for 5 cycles → `valid_in` stays high and the sample outputs stay stable. `ready_in`=1 → `ready_out` asserts next cycle.
- Three strobes during WAIT_Q → `drop_cnt`=2. After capture, the third sample is sent directly with no IDLE cycle.
- Hold `valid_out`=0 with TIMEOUT=16 → `timeout_err`=1 after 16 cycles in WAIT_Q. `q_seq` and `q_*_o` are unchanged; state returns to IDLE.
- Capture and `clr_new` in the same cycle → `q_new`=1. `clr_new` alone on the next cycle → `q_new`=0.
- Assert `rst_n`=0 during WAIT_Q with a pending sample → all outputs at reset values, `q_w_o`=16'h4000, no stale send after reset release.
